dpi_stream_dispatch: RTL and testbench

- Transmit side of the regex-matcher stream interface: parses incoming packets, maps each flow key to a 6-bit stream id, and drives the per-regex matcher bank.
- Drives load_state, new_stream_id, stream_id, the per-regex enable vector, char_in/char_in_vld and eop with the spacing the registered matcher wrappers require.
- Collects each matcher's fired flag at eop into a per-packet result.
- Sits between the packet ingress FIFO and the matcher bank in the DPI core.

---
 rtl/dpi_pkg.sv | 21 ++
 rtl/dpi_flow_table.sv | 52 +++++
 rtl/dpi_stream_dispatch.sv | 172 +++++++++++++++++
 tb/tb_dpi_stream_dispatch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_pkg.sv
// Shared definitions for the DPI stream dispatch block: FSM encoding,
// stream-id geometry and default matcher spacing.
package dpi_pkg;

    localparam int STREAM_ID_W       = 6;
    localparam int NUM_STREAMS       = 64;
    localparam int DEFAULT_LOAD_GAP  = 2;
    localparam int DEFAULT_EOP_DRAIN = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOOKUP,
        ST_LOAD,
        ST_GAP,
        ST_STREAM,
        ST_DRAIN,
        ST_EOP
    } dpi_state_e;

endpackage

// File: rtl/dpi_flow_table.sv
// 64-entry flow key store: parallel lookup, round-robin allocation on miss.
module dpi_flow_table
    import dpi_pkg::*;
#(
    parameter int KEY_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_W-1:0]       key,
    input  logic                   alloc_en,
    output logic [STREAM_ID_W-1:0] lookup_id,
    output logic                   lookup_new
);

    logic [KEY_W-1:0]       keys [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid;
    logic [STREAM_ID_W-1:0] alloc_ptr;
    logic                   hit;
    logic [STREAM_ID_W-1:0] hit_idx;

    // Allocation never duplicates a key, so at most one entry can match.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (valid[i] && (keys[i] == key)) begin
                hit     = 1'b1;
                hit_idx = STREAM_ID_W'(i);
            end
        end
    end

    assign lookup_id  = hit ? hit_idx : alloc_ptr;
    assign lookup_new = !hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid     <= '0;
            alloc_ptr <= '0;
        end else if (alloc_en && !hit) begin
            valid[alloc_ptr] <= 1'b1;
            alloc_ptr        <= alloc_ptr + STREAM_ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en && !hit) begin
            keys[alloc_ptr] <= key;
        end
    end

endmodule

// File: rtl/dpi_stream_dispatch.sv
// Regex-matcher transmit side: parses packets, maps flow keys to stream ids
// and drives the matcher bank with load/char/eop spacing, collecting results.
module dpi_stream_dispatch
    import dpi_pkg::*;
#(
    parameter int NUM_REGEX = 8,
    parameter int KEY_BYTES = 4,
    parameter int LOAD_GAP  = DEFAULT_LOAD_GAP,
    parameter int EOP_DRAIN = DEFAULT_EOP_DRAIN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           pkt_data,
    input  logic                 pkt_vld,
    input  logic                 pkt_eop,
    output logic                 pkt_rdy,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_addr,
    input  logic [NUM_REGEX-1:0] cfg_data,
    output logic                 load_state,
    output logic                 new_stream_id,
    output logic [5:0]           stream_id,
    output logic [NUM_REGEX-1:0] enable,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    input  logic [NUM_REGEX-1:0] fired,
    output logic                 result_vld,
    output logic [NUM_REGEX-1:0] result_fired,
    output logic [5:0]           result_stream_id,
    output logic [15:0]          drop_cnt
);

    localparam int               KEY_W      = 8 * KEY_BYTES;
    localparam int               HCNT_W     = $clog2(KEY_BYTES + 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(KEY_BYTES - 1);
    // Payload byte accepted LOAD_GAP-1 cycles after load_state reaches the
    // matchers LOAD_GAP cycles after it; an empty payload waits as if one did.
    localparam logic [7:0] WAIT_GAP   = 8'(LOAD_GAP - 3);
    localparam logic [7:0] WAIT_EMPTY = 8'(LOAD_GAP + EOP_DRAIN - 2);
    localparam logic [7:0] WAIT_DRAIN = 8'(EOP_DRAIN - 1);

    dpi_state_e             state_q, state_d;
    logic [HCNT_W-1:0]      hcnt_q;
    logic [KEY_W-1:0]       key_p0;
    logic                   zero_pay_q;
    logic [7:0]             wait_q;
    logic [STREAM_ID_W-1:0] stream_id_q;
    logic                   new_q;
    logic [NUM_REGEX-1:0]   enable_q;
    logic [7:0]             char_in_p1;
    logic                   char_in_vld_p1;
    logic [15:0]            drop_cnt_q;
    logic [NUM_REGEX-1:0]   en_tab [NUM_STREAMS];
    logic [STREAM_ID_W-1:0] lookup_id;
    logic                   lookup_new;
    logic                   xfer;
    logic                   eop_c;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    dpi_flow_table #(.KEY_W(KEY_W)) u_flow_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key_p0),
        .alloc_en   (state_q == ST_LOOKUP),
        .lookup_id  (lookup_id),
        .lookup_new (lookup_new)
    );

    assign xfer = pkt_vld && pkt_rdy;

    always_comb begin
        state_d    = state_q;
        pkt_rdy    = 1'b0;
        load_state = 1'b0;
        eop_c      = 1'b0;
        case (state_q)
            ST_IDLE:   if (pkt_vld) state_d = ST_HDR;
            ST_HDR: begin
                pkt_rdy = 1'b1;
                if (xfer) begin
                    if (hcnt_q == HCNT_LAST) state_d = ST_LOOKUP;
                    else if (pkt_eop)        state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: state_d = ST_LOAD;
            ST_LOAD: begin
                load_state = 1'b1;
                if (zero_pay_q)        state_d = ST_DRAIN;
                else if (LOAD_GAP > 2) state_d = ST_GAP;
                else                   state_d = ST_STREAM;
            end
            ST_GAP:    if (wait_q == 8'd0) state_d = ST_STREAM;
            ST_STREAM: begin
                pkt_rdy = 1'b1;
                if (xfer && pkt_eop) state_d = ST_DRAIN;
            end
            ST_DRAIN:  if (wait_q == 8'd0) state_d = ST_EOP;
            ST_EOP: begin
                eop_c   = 1'b1;
                state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            hcnt_q         <= '0;
            zero_pay_q     <= 1'b0;
            wait_q         <= '0;
            stream_id_q    <= '0;
            new_q          <= 1'b0;
            enable_q       <= '0;
            char_in_vld_p1 <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            char_in_vld_p1 <= xfer && (state_q == ST_STREAM);
            case (state_q)
                ST_IDLE: hcnt_q <= '0;
                ST_HDR: begin
                    if (xfer) begin
                        hcnt_q <= hcnt_q + HCNT_W'(1);
                        if (hcnt_q == HCNT_LAST) zero_pay_q <= pkt_eop;
                        else if (pkt_eop)        drop_cnt_q <= sat_inc(drop_cnt_q);
                    end
                end
                ST_LOOKUP: begin
                    stream_id_q <= lookup_id;
                    new_q       <= lookup_new;
                    enable_q    <= en_tab[lookup_id];
                end
                ST_LOAD:   wait_q <= zero_pay_q ? WAIT_EMPTY : WAIT_GAP;
                ST_GAP,
                ST_DRAIN:  wait_q <= wait_q - 8'd1;
                ST_STREAM: if (xfer && pkt_eop) wait_q <= WAIT_DRAIN;
                default: ;
            endcase
        end
    end

    // Header shift (first byte ends up most significant) and payload stage.
    always_ff @(posedge clk) begin
        if ((state_q == ST_HDR) && xfer) key_p0 <= {key_p0[KEY_W-9:0], pkt_data};
        char_in_p1 <= pkt_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) en_tab[i] <= '0;
        end else if (cfg_we) begin
            en_tab[cfg_addr] <= cfg_data;
        end
    end

    assign new_stream_id    = load_state && new_q;
    assign stream_id        = stream_id_q;
    assign enable           = enable_q;
    assign char_in          = char_in_p1;
    assign char_in_vld      = char_in_vld_p1;
    assign eop              = eop_c;
    assign result_vld       = eop_c;
    assign result_fired     = eop_c ? (fired & enable_q) : '0;
    assign result_stream_id = eop_c ? stream_id_q : '0;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_dpi_stream_dispatch.sv
// Directed bench for dpi_stream_dispatch: key mapping, spacing, results,
// runt drops, table wrap/eviction, enable timing and reset abandonment.
module tb_dpi_stream_dispatch;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pkt_data;
    logic        pkt_vld;
    logic        pkt_eop;
    logic        pkt_rdy;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        load_state;
    logic        new_stream_id;
    logic [5:0]  stream_id;
    logic [7:0]  enable;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        eop;
    logic [7:0]  fired;
    logic        result_vld;
    logic [7:0]  result_fired;
    logic [5:0]  result_stream_id;
    logic [15:0] drop_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Monitor snapshot
    int         ld_cnt = 0;
    int         ld_cyc = 0;
    logic       ld_new;
    logic [5:0] ld_id;
    logic [7:0] ld_en;
    int         nch = 0;
    logic [7:0] ch_dat [0:2047];
    int         ch_cyc [0:2047];
    int         eop_cnt = 0;
    int         eop_cyc = 0;
    logic       res_vld_s;
    logic [7:0] res_fired_s;
    logic [5:0] res_id_s;
    logic [7:0] eop_en_s;

    logic [7:0] pbuf [0:15];
    bit         mid_cfg = 0;

    dpi_stream_dispatch #(
        .NUM_REGEX (8),
        .KEY_BYTES (4),
        .LOAD_GAP  (2),
        .EOP_DRAIN (3)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pkt_data         (pkt_data),
        .pkt_vld          (pkt_vld),
        .pkt_eop          (pkt_eop),
        .pkt_rdy          (pkt_rdy),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .load_state       (load_state),
        .new_stream_id    (new_stream_id),
        .stream_id        (stream_id),
        .enable           (enable),
        .char_in          (char_in),
        .char_in_vld      (char_in_vld),
        .eop              (eop),
        .fired            (fired),
        .result_vld       (result_vld),
        .result_fired     (result_fired),
        .result_stream_id (result_stream_id),
        .drop_cnt         (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        check("pulse_onehot", 32'(int'(load_state) + int'(char_in_vld) + int'(eop) <= 1), 32'd1);
        if (load_state) begin
            ld_cnt = ld_cnt + 1;
            ld_cyc = cyc;
            ld_new = new_stream_id;
            ld_id  = stream_id;
            ld_en  = enable;
        end
        if (char_in_vld) begin
            ch_dat[nch] = char_in;
            ch_cyc[nch] = cyc;
            nch = nch + 1;
        end
        if (eop) begin
            eop_cnt     = eop_cnt + 1;
            eop_cyc     = cyc;
            res_vld_s   = result_vld;
            res_fired_s = result_fired;
            res_id_s    = result_stream_id;
            eop_en_s    = enable;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] addr, input logic [7:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Offers pbuf[0..len-1] (eop on the last), stopping after stop_at transfers.
    task automatic send(input int len, input int stop_at);
        int i = 0;
        int guard = 0;
        bit rdy;
        while (i < stop_at && guard < 300) begin
            pkt_vld  = 1'b1;
            pkt_data = pbuf[i];
            pkt_eop  = (i == len - 1);
            if (mid_cfg) begin
                cfg_we   = (i == 5);
                cfg_addr = 6'd0;
                cfg_data = 8'h01;
            end
            rdy = pkt_rdy;
            tick();
            if (rdy) i++;
            guard++;
        end
        pkt_vld = 1'b0;
        pkt_eop = 1'b0;
        cfg_we  = 1'b0;
        check("xfer_cnt", i, stop_at);
    endtask

    task automatic run_pkt(input logic [31:0] key, input logic [63:0] pay, input int plen,
                           input logic [5:0] exp_id, input logic exp_new,
                           input logic [7:0] exp_en, input bit with_cfg);
        int ld0 = ld_cnt;
        int n0  = nch;
        int e0  = eop_cnt;
        int k   = 0;
        for (int b = 0; b < 4; b++) pbuf[b] = key[31 - 8*b -: 8];
        for (int b = 0; b < plen; b++) pbuf[4 + b] = pay[8*(plen - b) - 1 -: 8];
        mid_cfg = with_cfg;
        send(4 + plen, 4 + plen);
        mid_cfg = 0;
        while (eop_cnt == e0 && k < 100) begin
            tick();
            k++;
        end
        check("eop_seen", eop_cnt, e0 + 1);
        check("load_cnt", ld_cnt, ld0 + 1);
        check("stream_id", ld_id, exp_id);
        check("new_stream_id", ld_new, exp_new);
        check("enable_at_load", ld_en, exp_en);
        check("char_cnt", nch - n0, plen);
        for (int b = 0; b < plen; b++) check("char_val", ch_dat[n0 + b], pbuf[4 + b]);
        if (plen > 0) begin
            check("load_to_char", ch_cyc[n0] - ld_cyc, 2);
            check("char_to_eop", eop_cyc - ch_cyc[n0 + plen - 1], 3);
        end else begin
            check("load_to_eop", eop_cyc - ld_cyc, 5);
        end
        check("result_vld", res_vld_s, 1'b1);
        check("result_stream_id", res_id_s, exp_id);
        check("result_fired", res_fired_s, exp_en & 8'hFF);
        check("enable_at_eop", eop_en_s, exp_en);
        tick();
        check("result_vld_after", result_vld, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int ld0;
        int e0;
        rst_n    = 1'b0;
        pkt_data = 8'h00;
        pkt_vld  = 1'b0;
        pkt_eop  = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 6'd0;
        cfg_data = 8'h00;
        fired    = 8'hFF;
        repeat (3) tick();

        check("rst_pkt_rdy", pkt_rdy, 1'b0);
        check("rst_load_state", load_state, 1'b0);
        check("rst_char_in_vld", char_in_vld, 1'b0);
        check("rst_eop", eop, 1'b0);
        check("rst_stream_id", stream_id, 6'd0);
        check("rst_enable", enable, 8'h00);
        check("rst_result_vld", result_vld, 1'b0);
        check("rst_result_fired", result_fired, 8'h00);
        check("rst_result_sid", result_stream_id, 6'd0);
        check("rst_drop_cnt", drop_cnt, 16'd0);
        rst_n = 1'b1;
        tick();

        cfg_write(6'd0, 8'h05);
        run_pkt(32'hDEADBEEF, 64'h616263, 3, 6'd0, 1'b1, 8'h05, 0);
        // Mid-packet cfg write to stream 0 must not disturb the held enable.
        run_pkt(32'hDEADBEEF, 64'h7879, 2, 6'd0, 1'b0, 8'h05, 1);
        run_pkt(32'h01020304, 64'h7A, 1, 6'd1, 1'b1, 8'h00, 0);
        run_pkt(32'hDEADBEEF, 64'h7A, 1, 6'd0, 1'b0, 8'h01, 0);

        // Runt: eop on the second header byte.
        ld0 = ld_cnt;
        pbuf[0] = 8'h99;
        pbuf[1] = 8'h88;
        send(2, 2);
        check("runt_pkt_rdy", pkt_rdy, 1'b0);
        check("runt_drop_cnt", drop_cnt, 16'd1);
        repeat (5) tick();
        check("runt_no_load", ld_cnt, ld0);
        run_pkt(32'h11111111, 64'h71, 1, 6'd2, 1'b1, 8'h00, 0);

        for (int k = 3; k < 64; k++) run_pkt(32'hA0000000 + k, 64'h6D, 1, 6'(k), 1'b1, 8'h00, 0);
        run_pkt(32'hB0000000, 64'h6E, 1, 6'd0, 1'b1, 8'h01, 0);
        run_pkt(32'hDEADBEEF, 64'h6F, 1, 6'd1, 1'b1, 8'h00, 0);

        run_pkt(32'h22222222, 64'h0, 0, 6'd2, 1'b1, 8'h00, 0);

        // Reset two payload bytes into a five-byte payload.
        e0 = eop_cnt;
        pbuf[0] = 8'h33; pbuf[1] = 8'h33; pbuf[2] = 8'h33; pbuf[3] = 8'h33;
        pbuf[4] = 8'h41; pbuf[5] = 8'h42; pbuf[6] = 8'h43; pbuf[7] = 8'h44; pbuf[8] = 8'h45;
        send(9, 6);
        check("pre_rst_char_vld", char_in_vld, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midrst_load_state", load_state, 1'b0);
        check("midrst_char_in_vld", char_in_vld, 1'b0);
        check("midrst_eop", eop, 1'b0);
        check("midrst_pkt_rdy", pkt_rdy, 1'b0);
        check("midrst_stream_id", stream_id, 6'd0);
        check("midrst_enable", enable, 8'h00);
        check("midrst_result_vld", result_vld, 1'b0);
        check("midrst_drop_cnt", drop_cnt, 16'd0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("midrst_no_eop", eop_cnt, e0);
        run_pkt(32'hDEADBEEF, 64'h6B, 1, 6'd0, 1'b1, 8'h00, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
